// File: rtl/key_entry_if.sv
// key_entry_if: keypad event, display and commit handshake bundle between scanner/consumer and key_entry_ctrl.
interface key_entry_if #(parameter int DIGITS = 4) ();
  logic [3:0]          key_num;
  logic                key_en;
  logic                out_ready;
  logic [4*DIGITS-1:0] out_data;
  logic                out_valid;
  logic [4*DIGITS-1:0] disp_data;
  logic [DIGITS-1:0]   disp_mask;
  logic                overflow;
  logic                busy;
  modport master (output key_num, key_en, out_ready, input out_data, out_valid, disp_data, disp_mask, overflow, busy);
  modport slave  (input key_num, key_en, out_ready, output out_data, out_valid, disp_data, disp_mask, overflow, busy);
endinterface

// File: rtl/key_entry_ctrl.sv
// key_entry_ctrl: sequences keypad events into a hex entry, shows it live and commits it over valid/ready.
// Optional backspace key is enabled by defining KEY_ENTRY_BACKSPACE_EN.
module key_entry_ctrl #(
  parameter int         DIGITS         = 4,
  parameter logic [3:0] ENTER_KEY      = 4'hE,
  parameter logic [3:0] CLEAR_KEY      = 4'hF,
  parameter logic [3:0] BKSP_KEY       = 4'hD,
  parameter int         TIMEOUT_CYCLES = 100000000-1,
  parameter int         TO_WIDTH       = 27
) (
  input logic clk,
  input logic rst_n,
  key_entry_if.slave bus
);
  localparam int W  = 4*DIGITS;
  localparam int CW = $clog2(DIGITS+1);
  localparam logic [CW-1:0]       FULL   = CW'(DIGITS);
  localparam logic [CW-1:0]       ONE    = CW'(1);
  localparam logic [TO_WIDTH-1:0] TO_MAX = TO_WIDTH'(TIMEOUT_CYCLES);
  typedef enum logic [1:0] {IDLE, ENTRY, HOLD} state_t;
  state_t state, state_nxt;
  logic [W-1:0] buf_q, buf_nxt, odata_q, odata_nxt;
  logic [CW-1:0] cnt_q, cnt_nxt;
  logic [DIGITS-1:0] mask_q;
  logic [TO_WIDTH-1:0] to_q, to_nxt;
  logic oval_q, oval_nxt, ovf_q, ovf_nxt, busy_q;
  logic is_ent, is_clr, is_bk, is_dig, full, timeout, accept;
  assign is_ent = bus.key_en && bus.key_num == ENTER_KEY;
  assign is_clr = bus.key_en && bus.key_num == CLEAR_KEY;
`ifdef KEY_ENTRY_BACKSPACE_EN
  assign is_bk = bus.key_en && bus.key_num == BKSP_KEY;
`else
  assign is_bk = 1'b0;
`endif
  assign is_dig  = bus.key_en && !is_ent && !is_clr && !is_bk;
  assign full    = cnt_q == FULL;
  assign timeout = state == ENTRY && !bus.key_en && to_q == TO_MAX;
  assign accept  = state == HOLD && oval_q && bus.out_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state == IDLE  ? (is_dig ? ENTRY : IDLE)
              : state == ENTRY ? (is_ent ? HOLD : (is_clr || timeout || (is_bk && cnt_q == ONE)) ? IDLE : ENTRY)
              : (accept ? IDLE : HOLD);
  end
  always_comb begin
    buf_nxt   = buf_q;
    cnt_nxt   = cnt_q;
    odata_nxt = odata_q;
    oval_nxt  = oval_q;
    ovf_nxt   = state == ENTRY && is_dig && full;
    if (state != HOLD && is_dig && !full) begin
      buf_nxt = W'({buf_q, bus.key_num});
      cnt_nxt = cnt_q + ONE;
    end
    if (state == ENTRY && is_bk) begin
      buf_nxt = buf_q >> 4;
      cnt_nxt = cnt_q - ONE;
    end
    if (state == ENTRY && is_ent) begin
      odata_nxt = buf_q;
      oval_nxt  = 1'b1;
    end
    if ((state == ENTRY && (is_clr || timeout)) || accept) begin
      buf_nxt = '0;
      cnt_nxt = '0;
    end
    if (accept) oval_nxt = 1'b0;
    to_nxt = (state_nxt == ENTRY && !bus.key_en) ? to_q + TO_WIDTH'(1) : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      buf_q   <= '0;
      cnt_q   <= '0;
      odata_q <= '0;
      oval_q  <= 1'b0;
      ovf_q   <= 1'b0;
      to_q    <= '0;
      mask_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      buf_q   <= buf_nxt;
      cnt_q   <= cnt_nxt;
      odata_q <= odata_nxt;
      oval_q  <= oval_nxt;
      ovf_q   <= ovf_nxt;
      to_q    <= to_nxt;
      mask_q  <= DIGITS'((64'd1 << cnt_nxt) - 64'd1);
      busy_q  <= state_nxt != IDLE;
    end
  assign bus.disp_data = buf_q;
  assign bus.disp_mask = mask_q;
  assign bus.out_data  = odata_q;
  assign bus.out_valid = oval_q;
  assign bus.overflow  = ovf_q;
  assign bus.busy      = busy_q;
endmodule
